// File: rtl/dunc_pkg.sv
// Shared opcode/state encodings and IR field offsets for the dunc accumulator core.
// The INDIR state exists only when DUNC_INDIRECT_EN is defined.
package dunc_pkg;

  typedef enum logic [3:0] {
    OP_HLT = 4'd0,
    OP_LDA = 4'd1,
    OP_STA = 4'd2,
    OP_ADD = 4'd3,
    OP_SUB = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_JMP = 4'd7,
    OP_JZ  = 4'd8,
    OP_JN  = 4'd9
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
`ifdef DUNC_INDIRECT_EN
    , S_INDIR
`endif
  } state_t;

  // Field positions are counted down from the IR MSB so they hold for any DATA_W.
  localparam int OPC_W       = 4;
  localparam int OPC_HI_OFS  = 0;
  localparam int OPC_LO_OFS  = OPC_W - 1;
  localparam int IND_BIT_OFS = OPC_W;

  function automatic logic is_data_op(input logic [3:0] op);
    return op inside {OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction

  function automatic logic uses_ea(input logic [3:0] op);
    return (op >= OP_LDA) && (op <= OP_JN);
  endfunction

endpackage

// File: rtl/dunc_alu.sv
// Combinational accumulator update: result = f(op, AC, memory operand).
// Unlisted opcodes pass AC through unchanged.
module dunc_alu
  import dunc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] md,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = ac;
    case (op)
      OP_LDA:  result = md;
      OP_ADD:  result = ac + md;
      OP_SUB:  result = ac - md;
      OP_AND:  result = ac & md;
      OP_OR:   result = ac | md;
      default: result = ac;
    endcase
  end

endmodule

// File: rtl/dunc_core.sv
// One-address accumulator CPU with a req/ack external memory port.
// Optional indirect addressing is enabled by defining DUNC_INDIRECT_EN.
module dunc_core
  import dunc_pkg::*;
#(
  parameter int                DATA_W = 16,
  parameter int                ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RST_PC = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              MEM_REQ,
  output logic              WRITE,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] MD_OUT,
  input  logic [DATA_W-1:0] MMO,
  input  logic              MEM_ACK,
  output logic [DATA_W-1:0] AC_OUT,
  output logic              I_STA,
  output logic              HALTED
);

  localparam int OPC_HI  = DATA_W - 1 - OPC_HI_OFS;
  localparam int OPC_LO  = DATA_W - 1 - OPC_LO_OFS;
  localparam int IND_BIT = DATA_W - 1 - IND_BIT_OFS;

  state_t            state, state_nx;
  logic [3:0]        opc;
  logic [ADDR_W-1:0] pc, ea;
  logic [DATA_W-1:0] ac, alu_y;
  logic              req, ack;
  logic              bus_state, start, sta_start;
  logic              jump_taken, indir_pend;

`ifdef DUNC_INDIRECT_EN
  logic ind;
  assign indir_pend = ind && uses_ea(opc);
`else
  assign indir_pend = 1'b0;
`endif

  assign ack     = req && MEM_ACK;
  assign MEM_REQ = req;
  assign AC_OUT  = ac;

  dunc_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (opc),
    .ac    (ac),
    .md    (MMO),
    .result(alu_y)
  );

  always_comb begin
    case (opc)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = (ac == '0);
      OP_JN:   jump_taken = ac[DATA_W-1];
      default: jump_taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: if (ack) state_nx = S_DECODE;
      S_DECODE: begin
        if (opc == OP_HLT)      state_nx = S_HALT;
`ifdef DUNC_INDIRECT_EN
        else if (indir_pend)    state_nx = S_INDIR;
`endif
        else if (is_data_op(opc)) state_nx = S_EXEC;
        else                    state_nx = S_FETCH;
      end
`ifdef DUNC_INDIRECT_EN
      S_INDIR: if (ack) state_nx = is_data_op(opc) ? S_EXEC : S_FETCH;
`endif
      S_EXEC:  if (ack) state_nx = S_FETCH;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    bus_state = 1'b0;
    case (state)
      S_FETCH, S_EXEC: bus_state = 1'b1;
`ifdef DUNC_INDIRECT_EN
      S_INDIR:         bus_state = 1'b1;
`endif
      default:         bus_state = 1'b0;
    endcase
    // Every transfer opens with one REQ-low setup cycle; that cycle is the mandatory gap.
    start     = bus_state && !req;
    sta_start = start && (state == S_EXEC) && (opc == OP_STA);
    HALTED    = (state == S_HALT);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      req     <= 1'b0;
      WRITE   <= 1'b0;
      ADDRESS <= '0;
      MD_OUT  <= '0;
      I_STA   <= 1'b0;
      pc      <= RST_PC;
      ac      <= '0;
      opc     <= '0;
      ea      <= '0;
`ifdef DUNC_INDIRECT_EN
      ind     <= 1'b0;
`endif
    end else begin
      I_STA <= sta_start;
      if (start) begin
        req     <= 1'b1;
        ADDRESS <= (state == S_FETCH) ? pc : ea;
        WRITE   <= sta_start;
        if (sta_start) MD_OUT <= ac;
      end else if (ack) begin
        req   <= 1'b0;
        WRITE <= 1'b0;
      end

      case (state)
        S_FETCH: if (ack) begin
          opc <= MMO[OPC_HI:OPC_LO];
          ea  <= MMO[ADDR_W-1:0];
`ifdef DUNC_INDIRECT_EN
          ind <= MMO[IND_BIT];
`endif
          pc  <= pc + ADDR_W'(1);
        end
        S_DECODE: if (!indir_pend && jump_taken) pc <= ea;
`ifdef DUNC_INDIRECT_EN
        S_INDIR: if (ack) begin
          ea <= MMO[ADDR_W-1:0];
          if (jump_taken) pc <= MMO[ADDR_W-1:0];
        end
`endif
        S_EXEC: if (ack && (opc != OP_STA)) ac <= alu_y;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dunc_core.sv
// Scoreboard bench for dunc_core: an ISA-level interpreter predicts every bus transfer,
// final AC, memory image, STA count and cycle total; a responder models wait-state memory.
`timescale 1ns/1ps
module tb_dunc_core;

  localparam int DW = 16;
  localparam int AW = 12;
`ifdef DUNC_INDIRECT_EN
  localparam bit IND_EN = 1'b1;
`else
  localparam bit IND_EN = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] data;
  } xfer_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          MEM_REQ, WRITE, I_STA, HALTED;
  logic [AW-1:0] ADDRESS;
  logic [DW-1:0] MD_OUT, AC_OUT;
  logic [DW-1:0] MMO = '0;
  logic          MEM_ACK = 1'b0;

  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] mm  [0:4095];
  xfer_t         exp_q[$];
  int            tests = 0, failed = 0;
  int            ack_delay = 0, wcnt = 0, sta_seen = 0;
  int            exp_tr, exp_n, exp_sta;
  logic [DW-1:0] exp_ac;
  bit            held = 1'b0;
  xfer_t         hold_v;

  dunc_core #(.DATA_W(DW), .ADDR_W(AW), .RST_PC(12'h000)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_REQ(MEM_REQ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .MD_OUT(MD_OUT), .MMO(MMO), .MEM_ACK(MEM_ACK), .AC_OUT(AC_OUT), .I_STA(I_STA),
    .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Memory responder: ack decided just after the edge, after ack_delay REQ-high cycles.
  always @(posedge CLK) begin
    #1;
    if (RESET || !MEM_REQ) begin
      MEM_ACK = 1'b0;
      wcnt    = 0;
    end else if (wcnt >= ack_delay) begin
      MEM_ACK = 1'b1;
      MMO     = mem[ADDRESS];
      if (WRITE) mem[ADDRESS] = MD_OUT;
    end else begin
      wcnt++;
      MEM_ACK = 1'b0;
    end
  end

  // Monitor: bus stability while REQ is held, and scoreboard pop on each completing transfer.
  always @(negedge CLK) begin
    xfer_t cur, e;
    if (RESET) begin
      held = 1'b0;
    end else begin
      if (I_STA) sta_seen++;
      if (MEM_REQ) begin
        cur = '{ADDRESS, WRITE, MD_OUT};
        if (held) chk("bus_stable", {3'b0, cur}, {3'b0, hold_v});
        else begin
          hold_v = cur;
          held   = 1'b1;
        end
        if (MEM_ACK) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL xfer_unexpected: got addr %h wr %b, expected no transfer", ADDRESS, WRITE);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_addr", {20'b0, ADDRESS}, {20'b0, e.addr});
            chk("xfer_write", {31'b0, WRITE}, {31'b0, e.wr});
            if (e.wr) chk("xfer_wdata", {16'b0, MD_OUT}, {16'b0, e.data});
          end
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // Instruction-level reference interpreter over a private copy of memory.
  task automatic model_run(output bit ok);
    logic [AW-1:0] pc, ea;
    logic [DW-1:0] ac, ir, v;
    int unsigned   op;
    for (int i = 0; i < 4096; i++) mm[i] = mem[i];
    exp_q.delete();
    pc = 12'h000; ac = '0; exp_n = 0; exp_tr = 0; exp_sta = 0; ok = 1'b0;
    while (exp_n < 150) begin
      exp_q.push_back('{pc, 1'b0, 16'h0000});
      ir = mm[pc];
      pc = pc + 12'd1;
      exp_n++; exp_tr++;
      op = ir[15:12];
      ea = ir[11:0];
      if (op == 0) begin
        ok = 1'b1;
        break;
      end
      if (op >= 10) continue;
      if (IND_EN && ir[11]) begin
        exp_q.push_back('{ea, 1'b0, 16'h0000});
        exp_tr++;
        v  = mm[ea];
        ea = v[11:0];
      end
      if (op <= 6) begin
        exp_tr++;
        if (op == 2) begin
          exp_q.push_back('{ea, 1'b1, ac});
          mm[ea] = ac;
          exp_sta++;
        end else begin
          exp_q.push_back('{ea, 1'b0, 16'h0000});
          v = mm[ea];
          case (op)
            1: ac = v;
            3: ac = ac + v;
            4: ac = ac - v;
            5: ac = ac & v;
            default: ac = ac | v;
          endcase
        end
      end else if (op == 7 || (op == 8 && ac == 16'h0000) || (op == 9 && ac[15])) begin
        pc = ea;
      end
    end
    exp_ac = ac;
  endtask

  task automatic clear_mem();
    RESET = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  task automatic run(input int delay, input string name);
    int cyc;
    bit done, ok;
    int bad;
    RESET = 1'b1;
    ack_delay = delay;
    model_run(ok);
    sta_seen = 0;
    repeat (2) @(negedge CLK);
    chk({name, ".reset"}, {MEM_REQ, WRITE, I_STA, HALTED, AC_OUT, 12'b0},
        {4'b0, 16'h0000, 12'b0});
    RESET = 1'b0;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 5000) begin
      @(negedge CLK);
      cyc++;
      if (HALTED) done = 1'b1;
    end
    chk({name, ".halted"}, {31'b0, done}, 32'd1);
    chk({name, ".cycles"}, cyc, exp_tr * (2 + delay) + exp_n);
    chk({name, ".ac"}, {16'b0, AC_OUT}, {16'b0, exp_ac});
    chk({name, ".sta_pulses"}, sta_seen, exp_sta);
    repeat (3) @(negedge CLK);
    chk({name, ".frozen"}, {MEM_REQ, HALTED, AC_OUT}, {1'b0, 1'b1, exp_ac});
    chk({name, ".queue_empty"}, exp_q.size(), 0);
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== mm[i]) bad++;
    chk({name, ".mem_image"}, bad, 0);
  endtask

  task automatic load_t1();
    clear_mem();
    mem[0] = 16'h100A; mem[1] = 16'h300B; mem[2] = 16'h200C; mem[3] = 16'h0000;
    mem[10] = 16'h0005; mem[11] = 16'h0003;
  endtask

  initial begin
    int d;
    bit ok;
    // Basic program, zero wait then three wait states.
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 0 : 3;
      load_t1();
      run(d, (k == 0) ? "t1" : "t2");
      chk("t1.m12", {16'b0, mem[12]}, 32'h0008);
      chk("t1.ac_spec", {16'b0, AC_OUT}, 32'h0008);
      chk("t1.sta_once", sta_seen, 1);
      chk("t1.cycles_spec", exp_tr * (2 + d) + exp_n, 18 + 7 * d);
    end

    // Conditional jumps: taken on zero, taken on negative, not taken on one.
    clear_mem();
    mem[0]  = 16'h1028; mem[1]  = 16'h8014;
    mem[20] = 16'h1029; mem[21] = 16'h901E;
    mem[30] = 16'h102A; mem[31] = 16'h8005; mem[32] = 16'h0000;
    mem[40] = 16'h0000; mem[41] = 16'h8000; mem[42] = 16'h0001;
    run(1, "t3");

    // Arithmetic wrap on ADD and SUB.
    clear_mem();
    mem[0] = 16'h1028; mem[1] = 16'h3029; mem[2] = 16'h202A;
    mem[3] = 16'h4029; mem[4] = 16'h202B; mem[5] = 16'h0000;
    mem[40] = 16'hFFFF; mem[41] = 16'h0001; mem[42] = 16'h5555;
    run(0, "t4");
    chk("t4.m42", {16'b0, mem[42]}, 32'h0000);
    chk("t4.ac_spec", {16'b0, AC_OUT}, 32'hFFFF);

    // PC wrap from 0xFFF to 0x000.
    clear_mem();
    mem[0]  = 16'h8020; mem[1] = 16'h0000;
    mem[32] = 16'h1028;
    mem[33] = IND_EN ? 16'h7900 : 16'h7FFF;
    mem[12'h900] = 16'h0FFF;
    mem[40] = 16'h0001;
    mem[12'hFFF] = 16'hA000;
    run(2, "t5");

    // Reset asserted while a read is outstanding.
    load_t1();
    ack_delay = 2;
    model_run(ok);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (9) @(negedge CLK);
    chk("t6.ac_before", {16'b0, AC_OUT}, 32'h0005);
    d = 0;
    while (!MEM_REQ && d < 10) begin
      @(negedge CLK);
      d++;
    end
    chk("t6.req_seen", {31'b0, MEM_REQ}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("t6.abort", {MEM_REQ, HALTED, I_STA, AC_OUT}, {3'b0, 16'h0000});
    load_t1();
    run(0, "t6.restart");

`ifdef DUNC_INDIRECT_EN
    // One-level indirect load: fetch, pointer read, operand read.
    clear_mem();
    mem[0] = 16'h1828; mem[1] = 16'h0000;
    mem[12'h828] = 16'h0032; mem[50] = 16'h1234;
    run(0, "t7");
    chk("t7.ac_spec", {16'b0, AC_OUT}, 32'h1234);
    chk("t7.transfers", exp_tr, 4);
`endif

    // Randomised programs over a small code/data/pointer region.
    for (int r = 0; r < 8; r++) begin
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        int unsigned op;
        logic [11:0] ea;
        clear_mem();
        for (int i = 0; i < 24; i++) begin
          op = $urandom_range(1, 15);
          if (op >= 7 && op <= 9) ea = 12'($urandom_range(0, 31));
          else if ($urandom_range(0, 3) == 0) ea = 12'h840 + 12'($urandom_range(0, 15));
          else ea = 12'd64 + 12'($urandom_range(0, 31));
          mem[i] = {op[3:0], ea};
        end
        for (int i = 64; i < 96; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 16; i++)
          mem[12'h840 + i] = ($urandom_range(0, 1) == 1) ? 16'(64 + $urandom_range(0, 31))
                                                        : 16'($urandom_range(0, 31));
        ack_delay = 0;
        model_run(ok);
      end
      if (ok) run($urandom_range(0, 3), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
